tick_bouncer: RTL and testbench

- Downstream consumer of the 16-bit tick generator: takes its one-cycle carry pulse (tick) as a step enable.
- Drives a one-hot "bouncing light" across an LED bar, paced by ticks, with start/stop key control.
- Counts wall bounces for display.
- Sits between the tick generator and the board LED/HEX drivers.

---
 rtl/tick_bouncer_pkg.sv | 12 +
 rtl/key_press_edge.sv | 19 +
 rtl/tick_bouncer.sv | 136 +++++++++++++
 tb/tb_tick_bouncer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_bouncer_pkg.sv
// Shared types and constants for the tick-paced bouncing-light block.
package tick_bouncer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } bstate_t;

  localparam logic [7:0] BOUNCE_MAX = 8'd255;

endpackage

// File: rtl/key_press_edge.sv
// Rising-edge detector for an already-synchronised key level.
module key_press_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic key_q;

  // History starts high so a key held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) key_q <= 1'b1;
    else       key_q <= key;
  end

  assign press = key & ~key_q;

endmodule

// File: rtl/tick_bouncer.sv
// One-hot light bouncing across an LED bar, stepped by divided ticks,
// with start/stop key control and a saturating wall-bounce counter.
module tick_bouncer
  import tick_bouncer_pkg::*;
#(
  parameter int unsigned N_LEDS = 10,
  parameter int unsigned DIV    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start_key,
  input  logic              stop_key,
  output logic [N_LEDS-1:0] leds,
  output logic              dir,
  output logic              running,
  output logic [7:0]        bounce_cnt
);

  localparam int unsigned PW = $clog2(N_LEDS);
  localparam logic [N_LEDS-1:0] LED_ONE = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] POS_TOP  = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_TURN = PW'(N_LEDS - 2);
  localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);

  bstate_t       state;
  logic [PW-1:0] pos;
  logic [7:0]    div_cnt;

  logic          start_press;
  logic          stop_press;
  logic          step;
  logic [PW-1:0] pos_nxt;
  logic          dir_nxt;
  logic          wall_hit;

  key_press_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .key   (start_key),
    .press (start_press)
  );

  key_press_edge u_stop_edge (
    .clk   (clk),
    .reset (reset),
    .key   (stop_key),
    .press (stop_press)
  );

  assign step = tick && (state == RUN) && (div_cnt == DIV_LAST);

  // Position/direction after one step; a wall reflects back one place.
  always_comb begin
    pos_nxt  = pos;
    dir_nxt  = dir;
    wall_hit = 1'b0;
    if (!dir) begin
      if (pos == POS_TOP) begin
        pos_nxt  = POS_TURN;
        dir_nxt  = 1'b1;
        wall_hit = 1'b1;
      end else begin
        pos_nxt = pos + PW'(1);
      end
    end else begin
      if (pos == '0) begin
        pos_nxt  = PW'(1);
        dir_nxt  = 1'b0;
        wall_hit = 1'b1;
      end else begin
        pos_nxt = pos - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pos        <= '0;
      leds       <= LED_ONE;
      dir        <= 1'b0;
      running    <= 1'b0;
      bounce_cnt <= 8'd0;
      div_cnt    <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_press && !stop_press) begin
            state   <= RUN;
            running <= 1'b1;
            div_cnt <= 8'd0;
          end
        end
        RUN: begin
          if (tick) begin
            if (step) begin
              div_cnt <= 8'd0;
              pos     <= pos_nxt;
              dir     <= dir_nxt;
              leds    <= LED_ONE << pos_nxt;
              if (wall_hit && bounce_cnt != BOUNCE_MAX) begin
                bounce_cnt <= bounce_cnt + 8'd1;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          // A step in the same cycle still lands before pausing.
          if (stop_press) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (stop_press) begin
            state      <= IDLE;
            pos        <= '0;
            leds       <= LED_ONE;
            dir        <= 1'b0;
            bounce_cnt <= 8'd0;
            div_cnt    <= 8'd0;
          end else if (start_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_bouncer.sv
// Scoreboard bench for tick_bouncer: a 4-LED/DIV=2 unit and a 2-LED/DIV=1 unit.
module tb_tick_bouncer;

  typedef struct {
    int         cyc;
    int         unit;
    logic [3:0] leds;
    logic       dir;
    logic       run;
    logic [7:0] bc;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_a = 1'b1, tick_a = 1'b0, start_a = 1'b0, stop_a = 1'b0;
  logic       reset_b = 1'b1, tick_b = 1'b0, start_b = 1'b0, stop_b = 1'b0;
  logic [3:0] leds_a;
  logic [1:0] leds_b;
  logic       dir_a, dir_b, running_a, running_b;
  logic [7:0] bc_a, bc_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Hand-computed light sequence for N_LEDS=4, index = steps taken.
  logic [3:0] seq_l [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic       seq_d [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] seq_b [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};

  tick_bouncer #(.N_LEDS(4), .DIV(2)) dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .tick       (tick_a),
    .start_key  (start_a),
    .stop_key   (stop_a),
    .leds       (leds_a),
    .dir        (dir_a),
    .running    (running_a),
    .bounce_cnt (bc_a)
  );

  tick_bouncer #(.N_LEDS(2), .DIV(1)) dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .tick       (tick_b),
    .start_key  (start_b),
    .stop_key   (stop_b),
    .leds       (leds_b),
    .dir        (dir_b),
    .running    (running_b),
    .bounce_cnt (bc_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation stamped for the current cycle.
  exp_t       e;
  logic [3:0] al;
  logic       ad, ar, ok;
  logic [7:0] ab;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.unit == 0) begin
        al = leds_a; ad = dir_a; ar = running_a; ab = bc_a;
        ok = 1'b1;
      end else begin
        al = {2'b00, leds_b}; ad = dir_b; ar = running_b; ab = bc_b;
        ok = $onehot(leds_b);
      end
      ok = ok && (e.cyc == cyc) && (al === e.leds) && (ad === e.dir) &&
           (ar === e.run) && (ab === e.bc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s cyc=%0d got leds=%b dir=%b run=%b bounce=%0d want leds=%b dir=%b run=%b bounce=%0d",
                 e.name, cyc, al, ad, ar, ab, e.leds, e.dir, e.run, e.bc);
      end
    end
  end

  task automatic drive_a(input logic r, input logic t, input logic s, input logic p);
    reset_a = r; tick_a = t; start_a = s; stop_a = p;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic r, input logic t, input logic s, input logic p);
    reset_b = r; tick_b = t; start_b = s; stop_b = p;
    @(posedge clk); #1;
  endtask

  task automatic expect_st(input int unit, input string nm, input logic [3:0] l,
                           input logic d, input logic rn, input logic [7:0] b);
    exp_t x;
    x.cyc = cyc; x.unit = unit; x.leds = l; x.dir = d; x.run = rn; x.bc = b; x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    // Reset both units for two cycles.
    drive_a(1, 0, 0, 0);
    drive_a(1, 0, 0, 0);
    expect_st(0, "reset_a", 4'b0001, 0, 0, 8'd0);
    expect_st(1, "reset_b", 4'b0001, 0, 0, 8'd0);
    drive_a(0, 0, 0, 0);
    expect_st(0, "idle_after_reset", 4'b0001, 0, 0, 8'd0);

    // Start, then 14 ticks: one step per two ticks.
    drive_a(0, 0, 1, 0);
    expect_st(0, "start_run", 4'b0001, 0, 1, 8'd0);
    for (int i = 0; i < 14; i++) begin
      drive_a(0, 1, 0, 0);
      expect_st(0, $sformatf("bounce_seq_tick%0d", i + 1), seq_l[(i + 1) / 2],
                seq_d[(i + 1) / 2], 1, seq_b[(i + 1) / 2]);
    end

    // Stop -> PAUSE, stop again -> IDLE, tick in IDLE ignored.
    drive_a(0, 0, 0, 1);
    expect_st(0, "pause", 4'b0010, 0, 0, 8'd2);
    drive_a(0, 0, 0, 0);
    drive_a(0, 0, 0, 1);
    expect_st(0, "pause_to_idle", 4'b0001, 0, 0, 8'd0);
    drive_a(0, 1, 0, 0);
    expect_st(0, "idle_tick_ignored", 4'b0001, 0, 0, 8'd0);

    // Run 3 ticks, pause, ticks ignored, resume keeps divider phase.
    drive_a(0, 0, 1, 0);
    expect_st(0, "restart", 4'b0001, 0, 1, 8'd0);
    drive_a(0, 1, 0, 0);
    expect_st(0, "mid_tick1", 4'b0001, 0, 1, 8'd0);
    drive_a(0, 1, 0, 0);
    expect_st(0, "mid_tick2", 4'b0010, 0, 1, 8'd0);
    drive_a(0, 1, 0, 0);
    expect_st(0, "mid_tick3", 4'b0010, 0, 1, 8'd0);
    drive_a(0, 0, 0, 1);
    expect_st(0, "mid_pause", 4'b0010, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      drive_a(0, 1, 0, 0);
      expect_st(0, $sformatf("pause_hold%0d", i), 4'b0010, 0, 0, 8'd0);
    end
    drive_a(0, 0, 1, 0);
    expect_st(0, "resume", 4'b0010, 0, 1, 8'd0);
    drive_a(0, 1, 0, 0);
    expect_st(0, "resume_div_kept", 4'b0100, 0, 1, 8'd0);

    // Simultaneous start+stop in PAUSE: stop wins -> IDLE.
    drive_a(0, 0, 0, 1);
    expect_st(0, "pause2", 4'b0100, 0, 0, 8'd0);
    drive_a(0, 0, 0, 0);
    drive_a(0, 0, 1, 1);
    expect_st(0, "both_keys_idle", 4'b0001, 0, 0, 8'd0);
    drive_a(0, 0, 0, 0);
    expect_st(0, "both_keys_stays_idle", 4'b0001, 0, 0, 8'd0);

    // Start held 10 cycles; a stop pulse mid-hold must stick in PAUSE.
    for (int i = 0; i < 10; i++) begin
      drive_a(0, 0, 1, (i == 4) ? 1'b1 : 1'b0);
      expect_st(0, $sformatf("start_held%0d", i), 4'b0001, 0, (i < 4) ? 1'b1 : 1'b0, 8'd0);
    end
    drive_a(0, 0, 0, 0);
    drive_a(0, 0, 0, 1);
    expect_st(0, "held_then_idle", 4'b0001, 0, 0, 8'd0);
    drive_a(0, 0, 0, 0);

    // Three bounces, then reset mid-run with start held through it.
    drive_a(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) drive_a(0, 1, 0, 0);
    expect_st(0, "three_bounces", 4'b0100, 1, 1, 8'd3);
    drive_a(1, 1, 1, 0);
    expect_st(0, "reset_mid_run", 4'b0001, 0, 0, 8'd0);
    drive_a(0, 1, 1, 0);
    expect_st(0, "held_through_reset", 4'b0001, 0, 0, 8'd0);
    drive_a(0, 0, 0, 0);

    // Saturation on the 2-LED unit: every step after the first bounces.
    drive_b(0, 0, 0, 0);
    expect_st(1, "b_idle", 4'b0001, 0, 0, 8'd0);
    drive_b(0, 0, 1, 0);
    expect_st(1, "b_start", 4'b0001, 0, 1, 8'd0);
    for (int k = 1; k <= 600; k++) begin
      drive_b(0, 1, 0, 0);
      if (k == 1)   expect_st(1, "b_step1", 4'b0010, 0, 1, 8'd0);
      if (k == 2)   expect_st(1, "b_step2", 4'b0001, 1, 1, 8'd1);
      if (k == 255) expect_st(1, "b_step255", 4'b0010, 0, 1, 8'd254);
      if (k == 256) expect_st(1, "b_sat", 4'b0001, 1, 1, 8'd255);
      if (k == 600) expect_st(1, "b_step600", 4'b0001, 1, 1, 8'd255);
    end
    drive_b(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
